// File: rtl/ring_buf_drain.sv
// Drains a multi-lane ring-buffer read port into a single valid/ready word stream.
// Lanes are taken as a contiguous valid prefix starting at lane 0 and emitted oldest first.
module ring_buf_drain #(
  parameter int unsigned DATA = 32,
  parameter int unsigned READ = 4,
  parameter bit          ACT  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [READ-1:0][DATA-1:0]  rd,
  input  logic [READ-1:0]            rv,
  output logic [READ-1:0]            re,
  output logic [DATA-1:0]            out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int unsigned CW = $clog2(READ) + 1;
  localparam int unsigned IW = (READ > 1) ? $clog2(READ) : 1;
  localparam logic ENABLE  = ACT ? 1'b1 : 1'b0;
  localparam logic DISABLE = ACT ? 1'b0 : 1'b1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [DATA-1:0] hold_q [READ];
  logic [DATA-1:0] hold_d [READ];
  logic [CW-1:0]   take;
  logic            stop;
  logic            last;
  logic            load_ok;

  // Lanes after the first non-valid lane are ignored, even if they are valid.
  always_comb begin
    take = '0;
    stop = 1'b0;
    for (int i = 0; i < READ; i++) begin
      if (!stop && (rv[i] == ENABLE)) begin
        take = CW'(i + 1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  assign last      = (idx_q == cnt_q - CW'(1));
  assign out_valid = (state_q == DRAIN);
  assign busy      = out_valid;
  // Reload is allowed when empty or while the final held word is being accepted.
  assign load_ok   = !reset && !flush &&
                     ((state_q == IDLE) || (out_valid && out_ready && last));

  always_comb begin
    for (int i = 0; i < READ; i++) begin
      re[i] = (load_ok && (CW'(i) < take)) ? ENABLE : DISABLE;
    end
  end

  assign out_data = out_valid ? hold_q[idx_q[IW-1:0]] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (load_ok && (take != '0)) begin
      for (int i = 0; i < READ; i++) begin
        if (CW'(i) < take) begin
          hold_d[i] = rd[i];
        end
      end
      cnt_d   = take;
      idx_d   = '0;
      state_d = DRAIN;
    end else if (out_valid && out_ready) begin
      if (!last) begin
        idx_d = idx_q + CW'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < READ; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: doc/ring_buf_drain.md
RING_BUF_DRAIN -- requirements
Module: ring_buf_drain

Interface
REQ-001 SHALL have parameter DATA, default 32: word width in bits.
REQ-002 SHALL have parameter READ, default 4: number of read lanes presented by the upstream ring buffer.
REQ-003 SHALL have parameter ACT, default HIGH: active level of re and rv; ENABLE/DISABLE are ACT ? 1 : 0 and ACT ? 0 : 1.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous active-high discard of held words.
REQ-007 SHALL have port rd  input  READ x DATA  upstream read-lane data, lane 0 oldest.
REQ-008 SHALL have port rv  input  READ  upstream lane-valid, ACT polarity.
REQ-009 SHALL have port re  output  READ  upstream lane read-enable, ACT polarity, combinational.
REQ-010 SHALL have port out_data  output  DATA  serialized word.
REQ-011 SHALL have port out_valid  output  1  out_data valid, active-high.
REQ-012 SHALL have port out_ready  input  1  downstream accept, active-high.
REQ-013 SHALL have port busy  output  1  high while any held word is not yet accepted.

Function
REQ-014 SHALL hold up to READ words in an internal register array hold[0..READ-1], with count cnt and index idx, each $clog2(READ)+1 bits wide.
REQ-015 SHALL define take as the length of the contiguous prefix of lanes, starting at lane 0, whose rv equals ENABLE; lanes after the first lane whose rv equals DISABLE SHALL be ignored.
REQ-016 SHALL implement states IDLE (hold empty) and DRAIN (idx < cnt).
REQ-017 SHALL define load_ok as state IDLE, or state DRAIN with out_valid, out_ready and idx == cnt-1, in both cases with flush low.
REQ-018 SHALL drive re[i] = ENABLE for i < take when load_ok is true; all other re bits SHALL be DISABLE.
REQ-019 SHALL, at a clock edge where load_ok is true and take > 0, capture rd[0..take-1] into hold[0..take-1], set cnt = take and idx = 0, and enter DRAIN.
REQ-020 SHALL, in IDLE with take == 0, remain in IDLE with re all DISABLE.
REQ-021 SHALL drive out_valid = 1 and out_data = hold[idx] in DRAIN, and out_valid = 0 in IDLE.
REQ-022 SHALL keep out_data stable while out_valid is high and out_ready is low.
REQ-023 SHALL, on a DRAIN edge with out_ready high and idx < cnt-1, increment idx.
REQ-024 SHALL, on a DRAIN edge with out_ready high and idx == cnt-1, return to IDLE when take == 0.
REQ-025 SHALL, on a DRAIN edge with out_ready high, idx == cnt-1 and take > 0, reload in that same edge, leaving no bubble in out_valid.
REQ-026 SHALL deliver the first word of a load on out_data exactly 1 cycle after re is asserted.
REQ-027 SHALL preserve lane order: the words of a load are emitted lane 0 first, and loads are emitted in arrival order.
REQ-028 SHALL drive busy = (state == DRAIN).
REQ-029 SHALL, when flush is high, force re all DISABLE in that cycle, and at the edge clear cnt and idx and enter IDLE; flush SHALL take priority over load and handshake.
REQ-030 SHALL drive out_data = 0 in IDLE.

Reset
REQ-031 SHALL, while reset is high, asynchronously force state IDLE, cnt = 0, idx = 0 and all hold words = 0.
REQ-032 SHALL, while reset is high, drive out_valid = 0, out_data = 0, busy = 0 and re all DISABLE.
REQ-033 SHALL discard in-progress words on reset asserted mid-DRAIN, with no partial word emitted after reset releases.
REQ-034 SHALL accept its first load at the first rising edge after reset deasserts.

Verification (DATA=32, READ=4, ACT=HIGH)
REQ-035 SHALL cover: rv=0011, rd lanes 1,2, out_ready=1 -> re=0011 for 1 cycle; then out_data 1, 2 on consecutive cycles; busy high 2 cycles.
REQ-036 SHALL cover: rv=1111, data A..D, out_ready low 3 cycles then high -> out_data holds A while stalled; then A, B, C, D; re stays 0000 until the cycle D is accepted.
REQ-037 SHALL cover: rv=1011 -> take=2; re=0011; only lanes 0 and 1 are emitted.
REQ-038 SHALL cover: back-to-back loads of 2 then 4 words with out_ready=1 -> 6 consecutive out_valid cycles with no gap, in order.
REQ-039 SHALL cover: flush during the second word of a 4-word load -> re=0000 that cycle; out_valid=0 and busy=0 the next cycle; the remaining words are never emitted.
REQ-040 SHALL cover: reset asserted mid-DRAIN -> out_valid, busy and re drop immediately without waiting for a clock edge; after release, the next rv load is emitted correctly.
